// File: rtl/exc_pkg.sv
// Shared definitions for the MEM-stage exception arbiter: excepttype codes,
// CP0 register addresses, the exception vector and exception-flag bit positions.
package exc_pkg;

   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
   localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
   localparam logic [31:0] EXC_RI      = 32'h0000_000a;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   // Bit positions inside mem_flags_i = {eret, trap, ov, break, syscall, ri, adel_if}
   localparam int FLAG_ADEL_IF = 0;
   localparam int FLAG_RI      = 1;
   localparam int FLAG_SYSCALL = 2;
   localparam int FLAG_BREAK   = 3;
   localparam int FLAG_OV      = 4;
   localparam int FLAG_TRAP    = 5;
   localparam int FLAG_ERET    = 6;

   typedef enum logic {
      ST_IDLE,
      ST_SHADOW
   } arb_state_e;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser, one independent chain per bit, for the raw interrupt lines.
module int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/exception_arbiter.sv
// MEM-stage exception detector/arbiter: picks one exception by fixed priority,
// registers the CP0 bundle for one cycle, and flushes/redirects the pipeline.
module exception_arbiter
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
   parameter int          SHADOW_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_i,
   input  logic        mem_valid_i,
   input  logic        mem_stall_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [6:0]  mem_flags_i,
   input  logic        mem_is_load_i,
   input  logic        mem_is_store_i,
   input  logic [1:0]  mem_size_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [5:0]  int_sync_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] cur_pc_o,
   output logic        in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES);

   arb_state_e  state, state_next;
   logic [2:0]  cnt, cnt_next;

   logic [31:0] status;
   logic [1:0]  cause_sw;
   logic [31:0] epc;
   logic        int_pending;
   logic        misaligned;
   logic [31:0] code;
   logic [31:0] bad_addr;
   logic        take;
   logic        unused_bits;

   int_sync #(.WIDTH(6)) u_int_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (int_i),
      .sync_out (int_sync_o)
   );

   // An mtc0 sitting in WB has not reached CP0 yet, so its data must win here.
   assign status   = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
   assign cause_sw = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)  ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8];
   assign epc      = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    ? wb_cp0_data_i : cp0_epc_i;

   assign int_pending = status[0] && !status[1]
                        && (({int_sync_o, cause_sw} & status[15:8]) != 8'h00);

   always_comb begin
      misaligned = 1'b0;
      case (mem_size_i)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = mem_addr_i[0];
         default: misaligned = (mem_addr_i[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      code     = EXC_NONE;
      bad_addr = 32'h0;
      if (int_pending) begin
         code = EXC_INT;
      end else if (mem_flags_i[FLAG_ADEL_IF]) begin
         code     = EXC_ADEL;
         bad_addr = mem_pc_i;
      end else if (mem_flags_i[FLAG_RI]) begin
         code = EXC_RI;
      end else if (mem_flags_i[FLAG_SYSCALL]) begin
         code = EXC_SYSCALL;
      end else if (mem_flags_i[FLAG_BREAK]) begin
         code = EXC_BREAK;
      end else if (mem_flags_i[FLAG_TRAP]) begin
         code = EXC_TRAP;
      end else if (mem_flags_i[FLAG_OV]) begin
         code = EXC_OV;
      end else if (misaligned && mem_is_load_i) begin
         code     = EXC_ADEL;
         bad_addr = mem_addr_i;
      end else if (misaligned && mem_is_store_i) begin
         code     = EXC_ADES;
         bad_addr = mem_addr_i;
      end else if (mem_flags_i[FLAG_ERET]) begin
         code = EXC_ERET;
      end
   end

   assign take = mem_valid_i && !mem_stall_i && (state == ST_IDLE) && (code != EXC_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The shadow covers the cycles in which flushed younger instructions may still appear in MEM.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (take) begin
               state_next = ST_SHADOW;
               cnt_next   = SHADOW_LOAD;
            end
         end
         ST_SHADOW: begin
            if (cnt <= 3'd1) begin
               state_next = ST_IDLE;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt - 3'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         excepttype_o   <= 32'h0;
         cur_pc_o       <= 32'h0;
         in_delayslot_o <= 1'b0;
         bad_addr_o     <= 32'h0;
         flush_o        <= 1'b0;
         new_pc_o       <= 32'h0;
      end else if (take) begin
         excepttype_o   <= code;
         cur_pc_o       <= mem_pc_i;
         in_delayslot_o <= mem_in_delayslot_i;
         bad_addr_o     <= bad_addr;
         flush_o        <= 1'b1;
         new_pc_o       <= (code == EXC_ERET) ? epc : EXC_VECTOR;
      end else begin
         excepttype_o   <= 32'h0;
         cur_pc_o       <= 32'h0;
         in_delayslot_o <= 1'b0;
         bad_addr_o     <= 32'h0;
         flush_o        <= 1'b0;
         new_pc_o       <= 32'h0;
      end
   end

   assign unused_bits = ^{cp0_cause_i[31:10], cp0_cause_i[7:0], status[31:16], status[7:2]};

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed bench for exception_arbiter: hand-computed vectors for priority,
// alignment, interrupts, forwarding, shadow window, stall and reset.
module tb_exception_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  int_i;
   logic        mem_valid_i;
   logic        mem_stall_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic [6:0]  mem_flags_i;
   logic        mem_is_load_i;
   logic        mem_is_store_i;
   logic [1:0]  mem_size_i;
   logic [31:0] mem_addr_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [5:0]  int_sync_o;
   logic [31:0] excepttype_o;
   logic [31:0] cur_pc_o;
   logic        in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] F_ADEL_IF = 7'b000_0001;
   localparam logic [6:0] F_RI      = 7'b000_0010;
   localparam logic [6:0] F_SYSCALL = 7'b000_0100;
   localparam logic [6:0] F_OV      = 7'b001_0000;
   localparam logic [6:0] F_ERET    = 7'b100_0000;

   exception_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .int_i              (int_i),
      .mem_valid_i        (mem_valid_i),
      .mem_stall_i        (mem_stall_i),
      .mem_pc_i           (mem_pc_i),
      .mem_in_delayslot_i (mem_in_delayslot_i),
      .mem_flags_i        (mem_flags_i),
      .mem_is_load_i      (mem_is_load_i),
      .mem_is_store_i     (mem_is_store_i),
      .mem_size_i         (mem_size_i),
      .mem_addr_i         (mem_addr_i),
      .cp0_status_i       (cp0_status_i),
      .cp0_cause_i        (cp0_cause_i),
      .cp0_epc_i          (cp0_epc_i),
      .wb_cp0_we_i        (wb_cp0_we_i),
      .wb_cp0_waddr_i     (wb_cp0_waddr_i),
      .wb_cp0_data_i      (wb_cp0_data_i),
      .int_sync_o         (int_sync_o),
      .excepttype_o       (excepttype_o),
      .cur_pc_o           (cur_pc_o),
      .in_delayslot_o     (in_delayslot_o),
      .bad_addr_o         (bad_addr_o),
      .flush_o            (flush_o),
      .new_pc_o           (new_pc_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic clearInputs();
      mem_valid_i        = 1'b0;
      mem_stall_i        = 1'b0;
      mem_pc_i           = 32'h0;
      mem_in_delayslot_i = 1'b0;
      mem_flags_i        = 7'h0;
      mem_is_load_i      = 1'b0;
      mem_is_store_i     = 1'b0;
      mem_size_i         = 2'd0;
      mem_addr_i         = 32'h0;
      wb_cp0_we_i        = 1'b0;
      wb_cp0_waddr_i     = 5'd0;
      wb_cp0_data_i      = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      clearInputs();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic [6:0] flags, input logic ds);
      mem_valid_i        = 1'b1;
      mem_pc_i           = pc;
      mem_flags_i        = flags;
      mem_in_delayslot_i = ds;
   endtask

   initial begin
      rst          = 1'b0;
      int_i        = 6'h0;
      cp0_status_i = 32'h0;
      cp0_cause_i  = 32'h0;
      cp0_epc_i    = 32'h0;
      clearInputs();
      tick();
      checkOutput("reset_excepttype", excepttype_o, 32'h0);
      checkOutput("reset_flush", {31'h0, flush_o}, 32'h0);
      checkOutput("reset_int_sync", {26'h0, int_sync_o}, 32'h0);
      checkOutput("reset_new_pc", new_pc_o, 32'h0);
      rst = 1'b1;
      tick();

      // syscall
      applyStimulus(32'hBFC0_0100, F_SYSCALL, 1'b0);
      tick();
      checkOutput("sys_type", excepttype_o, 32'h8);
      checkOutput("sys_pc", cur_pc_o, 32'hBFC0_0100);
      checkOutput("sys_ds", {31'h0, in_delayslot_o}, 32'h0);
      checkOutput("sys_flush", {31'h0, flush_o}, 32'h1);
      checkOutput("sys_newpc", new_pc_o, 32'hBFC0_0380);
      clearInputs();
      tick();
      checkOutput("sys_type_clear", excepttype_o, 32'h0);
      checkOutput("sys_flush_clear", {31'h0, flush_o}, 32'h0);
      idle(2);

      // misaligned word load
      applyStimulus(32'hBFC0_0110, 7'h0, 1'b0);
      mem_is_load_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h0000_0102;
      tick();
      checkOutput("adel_type", excepttype_o, 32'h4);
      checkOutput("adel_badaddr", bad_addr_o, 32'h0000_0102);
      checkOutput("adel_flush", {31'h0, flush_o}, 32'h1);
      idle(3);

      // misaligned half store
      applyStimulus(32'hBFC0_0114, 7'h0, 1'b0);
      mem_is_store_i = 1'b1; mem_size_i = 2'd1; mem_addr_i = 32'h0000_0003;
      tick();
      checkOutput("ades_type", excepttype_o, 32'h5);
      checkOutput("ades_badaddr", bad_addr_o, 32'h0000_0003);
      idle(3);

      // aligned word load and byte load at odd address take nothing
      applyStimulus(32'hBFC0_0118, 7'h0, 1'b0);
      mem_is_load_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h0000_0100;
      tick();
      checkOutput("aligned_word", excepttype_o, 32'h0);
      mem_size_i = 2'd0; mem_addr_i = 32'h0000_0003;
      tick();
      checkOutput("byte_odd", excepttype_o, 32'h0);
      checkOutput("byte_odd_flush", {31'h0, flush_o}, 32'h0);
      clearInputs();

      // interrupt: visible three cycles after int_i rises
      cp0_status_i = 32'h0000_0401;
      applyStimulus(32'hBFC0_0120, 7'h0, 1'b0);
      int_i = 6'b000001;
      tick();
      checkOutput("int_sync_1", {26'h0, int_sync_o}, 32'h0);
      checkOutput("int_type_1", excepttype_o, 32'h0);
      tick();
      checkOutput("int_sync_2", {26'h0, int_sync_o}, 32'h1);
      checkOutput("int_type_2", excepttype_o, 32'h0);
      tick();
      checkOutput("int_type_3", excepttype_o, 32'h1);
      checkOutput("int_flush_3", {31'h0, flush_o}, 32'h1);
      cp0_status_i = 32'h0000_0403;
      idle(3);

      // EXL set masks the interrupt
      applyStimulus(32'hBFC0_0124, 7'h0, 1'b0);
      tick();
      checkOutput("int_masked", excepttype_o, 32'h0);
      checkOutput("int_masked_flush", {31'h0, flush_o}, 32'h0);

      // mtc0 Status in WB clears EXL in the same cycle: forwarded value decides
      wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0401;
      tick();
      checkOutput("int_fwd_status", excepttype_o, 32'h1);
      int_i = 6'h0;
      cp0_status_i = 32'h0;
      idle(3);

      // ri + ov -> ri, then a held syscall is blocked exactly through the shadow
      applyStimulus(32'hBFC0_0130, F_RI | F_OV, 1'b0);
      tick();
      checkOutput("prio_ri_ov", excepttype_o, 32'ha);
      applyStimulus(32'hBFC0_0200, F_SYSCALL, 1'b0);
      tick();
      checkOutput("shadow_1", {31'h0, flush_o}, 32'h0);
      tick();
      checkOutput("shadow_2", excepttype_o, 32'h0);
      tick();
      checkOutput("shadow_3", excepttype_o, 32'h0);
      tick();
      checkOutput("shadow_end_type", excepttype_o, 32'h8);
      checkOutput("shadow_end_pc", cur_pc_o, 32'hBFC0_0200);
      idle(3);

      // interrupt beats syscall
      cp0_status_i = 32'h0000_0401;
      int_i = 6'b000001;
      tick(); tick();
      applyStimulus(32'hBFC0_0140, F_SYSCALL, 1'b0);
      tick();
      checkOutput("prio_int_sys", excepttype_o, 32'h1);
      int_i = 6'h0;
      cp0_status_i = 32'h0;
      idle(3);

      // eret with EPC forwarded from WB
      cp0_epc_i = 32'hBFC0_0000;
      applyStimulus(32'hBFC0_0150, F_ERET, 1'b0);
      wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h8000_1234;
      tick();
      checkOutput("eret_type", excepttype_o, 32'he);
      checkOutput("eret_newpc", new_pc_o, 32'h8000_1234);
      idle(3);

      // fetch AdEL in a delay slot outranks a misaligned data load
      applyStimulus(32'hBFC0_0203, F_ADEL_IF, 1'b1);
      mem_is_load_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h0000_0011;
      tick();
      checkOutput("adelif_type", excepttype_o, 32'h4);
      checkOutput("adelif_badaddr", bad_addr_o, 32'hBFC0_0203);
      checkOutput("adelif_ds", {31'h0, in_delayslot_o}, 32'h1);
      idle(3);

      // stall holds off the syscall until it drops
      applyStimulus(32'hBFC0_0300, F_SYSCALL, 1'b0);
      mem_stall_i = 1'b1;
      tick();
      checkOutput("stall_1", {31'h0, flush_o}, 32'h0);
      tick();
      checkOutput("stall_2", excepttype_o, 32'h0);
      mem_stall_i = 1'b0;
      tick();
      checkOutput("unstall_type", excepttype_o, 32'h8);
      checkOutput("unstall_flush", {31'h0, flush_o}, 32'h1);

      // async reset mid-shadow clears outputs at once and returns to IDLE
      clearInputs();
      rst = 1'b0;
      #1;
      checkOutput("rst_type", excepttype_o, 32'h0);
      checkOutput("rst_flush", {31'h0, flush_o}, 32'h0);
      checkOutput("rst_pc", cur_pc_o, 32'h0);
      checkOutput("rst_newpc", new_pc_o, 32'h0);
      rst = 1'b1;
      applyStimulus(32'hBFC0_0310, F_SYSCALL, 1'b0);
      tick();
      checkOutput("post_rst_take", excepttype_o, 32'h8);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
